pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the MIPS processor. Holds the architectural PC, drives instruction memory through a req/ready handshake, and presents the fetched instruction to decode. Produces PC+4 for `Adder_Branch` and consumes its branch-target result to select the next PC.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the current instruction; no PC update.
- `branch`  in  1  decoded branch instruction in EXEC.
- `zero`  in  1  ALU zero flag for the instruction in EXEC.
- `branch_target`  in  32  absolute branch target from `Adder_Branch`.
- `jump`  in  1  decoded jump instruction in EXEC.
- `jump_index`  in  26  instr[25:0] of the jump.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (= `pc`).
- `imem_ready`  in  1  memory accepts request and returns data this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_req & imem_ready`.
- `instr`  out  32  latched instruction.
- `instr_valid`  out  1  `instr` is valid for decode/execute.
- `pc`  out  32  current PC.
- `pc_4`  out  32  `pc + 4` (combinational), fed to `Adder_Branch` `PC_4`.
- `fetch_err`  out  1  sticky misaligned-next-PC error.

## Operation
- States: IDLE, REQ, EXEC, HALT.
- IDLE: entered on reset; unconditionally goes to REQ on the next edge.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On an edge with `imem_ready`=1, latch `imem_rdata` into `instr` and go to EXEC. Otherwise stay in REQ.
- EXEC: `instr_valid`=1.
  - `stall`=1: stay in EXEC; `instr` and `pc` are held.
  - `stall`=0: `pc` <= next PC and go to REQ.
- Next-PC priority:
  - `jump`: {`pc_4`[31:28], `jump_index`, 2'b00}.
  - else `branch & zero`: `branch_target`.
  - else `pc_4`.
- `jump` and `branch` both high: the jump wins.
- Misalignment: if the selected next PC has [1:0] != 0, `pc` is not updated, `fetch_err` sets, and the FSM goes to HALT.
- HALT: all requests stop. Only reset leaves HALT.
- Wrap-around: `pc`=32'hFFFF_FFFC gives `pc_4`=32'h0000_0000, silently, with no error.
- `branch`, `zero` and `jump` are ignored outside EXEC.
- `imem_rdata` is ignored unless the state is REQ and `imem_ready`=1.

## Timing
- Reset values (asserted immediately, asynchronously):
  - `pc`=`RESET_PC`, state IDLE, `imem_req`=0, `instr`=32'h0, `instr_valid`=0, `fetch_err`=0.
  - `imem_addr`=`RESET_PC` and `pc_4`=`RESET_PC`+4 follow from `pc`.
- Reset mid-handshake: `imem_req` drops at once. Any in-flight data is discarded.
- Edge 1 after `rst_n` rises: IDLE->REQ. `imem_req` goes high in that cycle.
- All outputs except `pc_4`, `imem_addr` and `imem_addr`-derived values are registered or Moore outputs, with no combinational path from `imem_ready`.
- While in REQ, `imem_addr` stays stable until the transfer edge.
- With zero-wait memory (`imem_ready` always 1), throughput is one instruction per 2 cycles (REQ, EXEC). Each wait cycle adds one cycle.
- The new `pc` is visible in the cycle after the EXEC edge, and its REQ starts in that same cycle.

## Structure
- Shared package `mips_pkg`:
  - fetch state typedef (IDLE/REQ/EXEC/HALT);
  - `RESET_PC` default;
  - `NOP_INSTR`=32'h0;
  - the jump upper-bit slice constant (31:28).
- Sub-module `pc_next_mux`: combinational next-PC select and misalignment detect. It takes `pc_4`, `branch_target`, `jump_index`, `branch`, `zero` and `jump`, and returns `next_pc` and `misaligned`.
- The top level contains the FSM, the PC register and the instruction latch.

## Test plan
- Reset/sequential: `RESET_PC`=0, `imem_ready`=1, no branch/jump. Expect `imem_addr` sequence 0,4,8,12 on every second cycle, and `instr_valid` high in alternate cycles.
- Wait states: hold `imem_ready`=0 for 3 cycles in REQ at `pc`=8. Expect `imem_req` high with `imem_addr`=8 held, no `instr_valid`, and `instr`=`imem_rdata` latched on the ready edge.
- Branch: `pc`=4 (`pc_4`=8), `branch`=1, `zero`=1, `branch_target`=32'h48. Expect next `imem_addr`=32'h48. Repeat with `zero`=0 and expect 8.
- Jump priority: `pc`=32'h1000_0000, `jump`=1, `jump_index`=26'h10, `branch`=`zero`=1. Expect next `pc`=32'h1000_0040.
- Stall, error, wrap:
  - `stall`=1 for 4 cycles in EXEC: `pc` and `instr` held.
  - `branch_target`=32'h22 taken: `fetch_err`=1, HALT, `imem_req`=0 until reset.
  - `RESET_PC`=32'hFFFF_FFFC: next fetch at 0.
- Async reset mid-REQ: drop `rst_n` between edges. Expect `imem_req`=0 and `pc`=`RESET_PC` before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM state encoding and fetch-stage constants.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Jump targets keep the region bits of pc_4 at these positions.
    localparam int JUMP_HI_MSB = 31;
    localparam int JUMP_HI_LSB = 28;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select (jump > taken branch > sequential) and word-alignment check.
module pc_next_mux
    import mips_pkg::*;
(
    input  logic [31:0] pc_4,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] jump_pc;

    assign jump_pc = {pc_4[JUMP_HI_MSB:JUMP_HI_LSB], jump_index, 2'b00};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        next_pc = pc_4;
        if (jump) begin
            next_pc = jump_pc;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, instruction latch and the IDLE/REQ/EXEC/HALT handshake FSM.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_4,
    output logic        fetch_err
);

    fetch_state_t state, state_next;

    logic [31:0] next_pc;
    logic        misaligned;
    logic        pc_load;
    logic        instr_load;
    logic        err_set;

    assign pc_4      = pc + 32'd4;
    assign imem_addr = pc;

    // Moore outputs: decoded from state only, never from imem_ready.
    assign imem_req    = (state == ST_REQ);
    assign instr_valid = (state == ST_EXEC);

    pc_next_mux u_pc_next_mux (
        .pc_4          (pc_4),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .branch        (branch),
        .zero          (zero),
        .jump          (jump),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        instr_load = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (imem_ready) begin
                    instr_load = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (misaligned) begin
                        err_set    = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        pc_load    = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            instr     <= NOP_INSTR;
            fetch_err <= 1'b0;
        end else begin
            state <= state_next;
            if (pc_load) begin
                pc <= next_pc;
            end
            if (instr_load) begin
                instr <= imem_rdata;
            end
            if (err_set) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (RESET_PC=0 main DUT, RESET_PC=FFFF_FFFC wrap DUT).
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        fetch_err;

    logic        rst2_n;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] instr2;
    logic        instr_valid2;
    logic [31:0] pc2;
    logic [31:0] pc_42;
    logic        fetch_err2;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_4          (pc_4),
        .fetch_err     (fetch_err)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst2_n),
        .stall         (1'b0),
        .branch        (1'b0),
        .zero          (1'b0),
        .branch_target (32'h0),
        .jump          (1'b0),
        .jump_index    (26'h0),
        .imem_req      (imem_req2),
        .imem_addr     (imem_addr2),
        .imem_ready    (1'b1),
        .imem_rdata    (32'h0000_0777),
        .instr         (instr2),
        .instr_valid   (instr_valid2),
        .pc            (pc2),
        .pc_4          (pc_42),
        .fetch_err     (fetch_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        jump          = 1'b0;
        branch_target = 32'h0;
        jump_index    = 26'h0;
        imem_ready    = 1'b1;
        imem_rdata    = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (pc_4 !== 32'h4) begin errors++; $display("FAIL reset_pc_4 got %h exp %h", pc_4, 32'h4); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'h0); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", fetch_err); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_edge_req got %b exp 1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_addr   = 32'(k * 4);
            exp_instr  = 32'hA000_0000 | exp_addr;
            imem_rdata = exp_instr;
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b0) begin
                errors++; $display("FAIL seq_req k=%0d got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", k, imem_req, imem_addr, instr_valid, exp_addr);
            end
            tick();
            checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== exp_instr) begin
                errors++; $display("FAIL seq_exec k=%0d got valid=%b req=%b instr=%h exp valid=1 req=0 instr=%h", k, instr_valid, imem_req, instr, exp_instr);
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        imem_rdata = 32'h0000_1234;
        repeat (5) tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_0000;
        for (int w = 0; w < 3; w++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL wait_hold w=%0d got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", w, imem_req, imem_addr, instr_valid, 32'h8);
            end
        end
        checks++; if (instr !== 32'h0000_1234) begin errors++; $display("FAIL wait_instr_held got %h exp %h", instr, 32'h0000_1234); end
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_0008;
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0008) begin
            errors++; $display("FAIL wait_latch got valid=%b instr=%h exp valid=1 instr=%h", instr_valid, instr, 32'hCAFE_0008);
        end
        stall      = 1'b1;
        imem_rdata = 32'hFFFF_0000;
        tick();
        checks++; if (instr !== 32'hCAFE_0008) begin errors++; $display("FAIL rdata_ignored_exec got %h exp %h", instr, 32'hCAFE_0008); end
        stall = 1'b0;
    endtask

    task automatic test_branch(input logic zero_val, input logic [31:0] exp_pc);
        do_reset();
        repeat (3) tick();
        branch        = 1'b1;
        zero          = zero_val;
        branch_target = 32'h48;
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL branch_ignored_req zero=%b got %h exp %h", zero_val, pc, 32'h4); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            errors++; $display("FAIL branch_next zero=%b got req=%b addr=%h exp req=1 addr=%h", zero_val, imem_req, imem_addr, exp_pc);
        end
        branch = 1'b0;
        zero   = 1'b0;
    endtask

    task automatic test_jump_priority();
        do_reset();
        repeat (2) tick();
        branch        = 1'b1;
        zero          = 1'b1;
        branch_target = 32'h1000_0000;
        tick();
        checks++; if (pc !== 32'h1000_0000) begin errors++; $display("FAIL jump_setup_pc got %h exp %h", pc, 32'h1000_0000); end
        branch = 1'b0;
        zero   = 1'b0;
        tick();
        jump          = 1'b1;
        jump_index    = 26'h10;
        branch        = 1'b1;
        zero          = 1'b1;
        branch_target = 32'h48;
        tick();
        checks++; if (pc !== 32'h1000_0040 || imem_addr !== 32'h1000_0040) begin
            errors++; $display("FAIL jump_priority got pc=%h addr=%h exp %h", pc, imem_addr, 32'h1000_0040);
        end
        jump   = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        imem_rdata = 32'h2222_0000;
        repeat (2) tick();
        stall      = 1'b1;
        imem_rdata = 32'h3333_3333;
        for (int s = 0; s < 4; s++) begin
            tick();
            checks++; if (pc !== 32'h0 || instr !== 32'h2222_0000 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold s=%0d got pc=%h instr=%h valid=%b req=%b exp pc=0 instr=%h valid=1 req=0", s, pc, instr, instr_valid, imem_req, 32'h2222_0000);
            end
        end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h4 || imem_req !== 1'b1) begin
            errors++; $display("FAIL stall_release got pc=%h req=%b exp pc=%h req=1", pc, imem_req, 32'h4);
        end
    endtask

    task automatic test_error();
        do_reset();
        repeat (2) tick();
        branch        = 1'b1;
        zero          = 1'b1;
        branch_target = 32'h22;
        tick();
        checks++; if (fetch_err !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL misalign got err=%b pc=%h req=%b valid=%b exp err=1 pc=0 req=0 valid=0", fetch_err, pc, imem_req, instr_valid);
        end
        branch = 1'b0;
        zero   = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin
                errors++; $display("FAIL halt_hold h=%0d got req=%b err=%b exp req=0 err=1", h, imem_req, fetch_err);
            end
        end
        do_reset();
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", fetch_err); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL halt_exit_req got %b exp 1", imem_req); end
    endtask

    task automatic test_wrap();
        rst2_n = 1'b0;
        #1;
        checks++; if (pc2 !== 32'hFFFF_FFFC || pc_42 !== 32'h0) begin
            errors++; $display("FAIL wrap_reset got pc=%h pc_4=%h exp pc=%h pc_4=%h", pc2, pc_42, 32'hFFFF_FFFC, 32'h0);
        end
        tick();
        rst2_n = 1'b1;
        tick();
        checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first got req=%b addr=%h exp req=1 addr=%h", imem_req2, imem_addr2, 32'hFFFF_FFFC);
        end
        tick();
        checks++; if (instr_valid2 !== 1'b1 || instr2 !== 32'h0000_0777) begin
            errors++; $display("FAIL wrap_exec got valid=%b instr=%h exp valid=1 instr=%h", instr_valid2, instr2, 32'h0000_0777);
        end
        tick();
        checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0 || fetch_err2 !== 1'b0) begin
            errors++; $display("FAIL wrap_next got req=%b addr=%h err=%b exp req=1 addr=0 err=0", imem_req2, imem_addr2, fetch_err2);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_rdata = 32'h4444_0000;
        repeat (3) tick();
        imem_ready = 1'b0;
        imem_rdata = 32'h5555_5555;
        checks++; if (imem_req !== 1'b1 || pc !== 32'h4) begin
            errors++; $display("FAIL async_pre got req=%b pc=%h exp req=1 pc=%h", imem_req, pc, 32'h4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
            errors++; $display("FAIL async_reset got req=%b pc=%h instr=%h exp req=0 pc=0 instr=0", imem_req, pc, instr);
        end
        imem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL async_restart got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    initial begin
        rst2_n = 1'b0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch(1'b1, 32'h48);
        test_branch(1'b0, 32'h8);
        test_jump_priority();
        test_stall();
        test_error();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
